// File: rtl/led_pkg.sv
// Shared types and default constants for the LED fade driver family.
// Purpose only; no logic lives here.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_t;

    localparam int PWM_BITS_DEF    = 8;
    localparam int STEP_DIV_DEF    = 1024;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/led_fade_driver_if.sv
// Purpose: bundles the blink input, enable and LED drive/status outputs of the fade driver.
// Latency: none, wires only.
// Backpressure: none, level-based signals.
interface led_fade_driver_if
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
);
    logic                Blink_IN;
    logic                Enable;
    logic                LED_OUT;
    logic [PWM_BITS-1:0] Level;
    logic                Ramping;

    modport master (
        output Blink_IN,
        output Enable,
        input  LED_OUT,
        input  Level,
        input  Ramping
    );

    modport slave (
        input  Blink_IN,
        input  Enable,
        output LED_OUT,
        output Level,
        output Ramping
    );

endinterface

// File: rtl/bit_sync.sv
// Purpose: N-flop single-bit synchronizer for asynchronous inputs.
// Latency: STAGES cycles from d to q.
// Backpressure: none, free-running.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/led_fade_driver.sv
// Purpose: turns blink level edges into linear brightness ramps driving a PWM LED output.
// Latency: ramp starts SYNC_STAGES cycles after a blink edge; LED_OUT lags Level/pwm by one cycle.
// Backpressure: none; Enable=0 blanks the LED and freezes state, Level and prescaler.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         Clock_IN,
    input  logic         Reset,
    led_fade_driver_if.slave fade
);

    localparam int                  CNT_W    = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

    fade_state_t         state, state_nxt;
    logic [CNT_W-1:0]    step_cnt;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] target;
    logic                blink_s;
    logic                tick;
    logic                led_q;
    logic                ramping_q;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_blink_sync (
        .core_clk (Clock_IN),
        .arst_n   (Reset),
        .d        (fade.Blink_IN),
        .q        (blink_s)
    );

    // Direction is re-decided every enabled cycle, so a reversal mid-ramp goes straight UP<->DOWN.
    always_comb begin
        state_nxt = state;
        target    = blink_s ? PWM_MAX : '0;
        tick      = (step_cnt == CNT_LAST) && (state != IDLE);
        if (fade.Enable) begin
            if (target > level) begin
                state_nxt = UP;
            end else if (target < level) begin
                state_nxt = DOWN;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge Clock_IN or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            level     <= '0;
            pwm_cnt   <= '0;
            led_q     <= 1'b0;
            ramping_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pwm_cnt   <= pwm_cnt + 1'b1;
            led_q     <= fade.Enable & ((level == PWM_MAX) | (pwm_cnt < level));
            ramping_q <= (state_nxt != IDLE);
            if (fade.Enable) begin
                // Prescaler restarts from zero on every fresh ramp but runs on through a reversal.
                if ((state == IDLE) || (state_nxt == IDLE)) begin
                    step_cnt <= '0;
                end else if (step_cnt == CNT_LAST) begin
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
                if (tick) begin
                    if ((state == UP) && (level != PWM_MAX)) begin
                        level <= level + 1'b1;
                    end else if ((state == DOWN) && (level != '0)) begin
                        level <= level - 1'b1;
                    end
                end
            end
        end
    end

    assign fade.LED_OUT = led_q;
    assign fade.Level   = level;
    assign fade.Ramping = ramping_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Randomised self-checking bench for led_fade_driver against a cycle-level behavioural model.
module tb_led_fade_driver;

    localparam int STEP = 4;
    localparam int MAXL = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_fade_driver_if #(.PWM_BITS(8)) fade ();

    led_fade_driver #(
        .PWM_BITS    (8),
        .STEP_DIV    (STEP),
        .SYNC_STAGES (2)
    ) dut (
        .Clock_IN (clk),
        .Reset    (rst_n),
        .fade     (fade)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: direction -1/0/+1, brightness, phase within the current step period.
    int m_lvl, m_dir, m_phase, m_pwm, m_led, m_ramp;
    int m_sync0, m_sync1;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0; m_dir = 0; m_phase = 0; m_pwm = 0;
        m_led = 0; m_ramp = 0; m_sync0 = 0; m_sync1 = 0;
    endtask

    task automatic model_edge(input int b, input int en);
        int tgt;
        int dn;
        int old_lvl;
        old_lvl = m_lvl;
        tgt     = (m_sync1 != 0) ? MAXL : 0;
        m_led   = (en != 0) && (old_lvl == MAXL || m_pwm < old_lvl);
        if (en != 0) begin
            dn = (tgt > old_lvl) ? 1 : ((tgt < old_lvl) ? -1 : 0);
            if (m_dir != 0 && m_phase == STEP - 1) begin
                m_lvl = old_lvl + m_dir;
                if (m_lvl > MAXL) m_lvl = MAXL;
                if (m_lvl < 0) m_lvl = 0;
            end
            m_phase = (m_dir == 0 || dn == 0) ? 0 : (m_phase + 1) % STEP;
            m_dir   = dn;
        end
        m_ramp  = (m_dir != 0);
        m_pwm   = (m_pwm + 1) % 256;
        m_sync1 = m_sync0;
        m_sync0 = b;
    endtask

    // One clock: apply inputs, advance model at the edge, compare just after it.
    task automatic step(input int b, input int en);
        fade.Blink_IN = b[0];
        fade.Enable   = en[0];
        @(posedge clk);
        model_edge(b, en);
        cyc++;
        #1;
        check_eq("level",   32'(fade.Level),   m_lvl);
        check_eq("ramping", 32'(fade.Ramping), m_ramp);
        check_eq("led_out", 32'(fade.LED_OUT), m_led);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_level",   32'(fade.Level),   0);
        check_eq("rst_ramping", 32'(fade.Ramping), 0);
        check_eq("rst_led",     32'(fade.LED_OUT), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int t_ramp, t_one, t_full, t_fall;
        int prev, max_jump, lvl_frz, led_hi, ramp_hi, lvl_max;
        int b, len;

        fade.Blink_IN = 1'b0;
        fade.Enable   = 1'b1;
        model_reset();
        #23;
        check_eq("init_level",   32'(fade.Level),   0);
        check_eq("init_ramping", 32'(fade.Ramping), 0);
        check_eq("init_led",     32'(fade.LED_OUT), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1);

        // Ramp-up timing relative to the edge that first samples Blink_IN=1.
        step(1, 1);
        k = cyc;
        t_ramp = -1; t_one = -1; t_full = -1; t_fall = -1;
        for (int i = 0; i < 1200 && t_fall < 0; i++) begin
            step(1, 1);
            if (t_ramp < 0 && fade.Ramping === 1'b1) t_ramp = cyc;
            if (t_one  < 0 && fade.Level == 8'd1)    t_one  = cyc;
            if (t_full < 0 && fade.Level == 8'd255)  t_full = cyc;
            if (t_full >= 0 && t_fall < 0 && fade.Ramping === 1'b0) t_fall = cyc;
        end
        check_eq("up_ramping_edge", 32'(t_ramp - k), 2);
        check_eq("up_first_step",   32'(t_one - k),  6);
        check_eq("up_full_edge",    32'(t_full - k), 1022);
        check_eq("up_ramp_fall",    32'(t_fall - k), 1023);

        // Full brightness: constant 1 over one PWM period.
        led_hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1, 1);
            led_hi += int'(fade.LED_OUT);
        end
        check_eq("duty_full", 32'(led_hi), 256);

        // Fade back down, then zero brightness: constant 0.
        for (int i = 0; i < 1100 && !(m_lvl == 0 && m_ramp == 0); i++) step(0, 1);
        for (int i = 0; i < 4; i++) step(0, 1);
        led_hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 1);
            led_hi += int'(fade.LED_OUT);
        end
        check_eq("duty_zero", 32'(led_hi), 0);

        // Reversal at Level=100 just after a step: no jump, ends at 0.
        for (int i = 0; i < 600 && !(m_lvl == 100 && m_phase == 0); i++) step(1, 1);
        check_eq("rev_start_level", 32'(fade.Level), 100);
        prev = 100; max_jump = 0; lvl_max = 0;
        for (int i = 0; i < 600 && !(i > 4 && m_ramp == 0); i++) begin
            step(0, 1);
            if (fade.Level > lvl_max) lvl_max = int'(fade.Level);
            if (int'(fade.Level) - prev > max_jump) max_jump = int'(fade.Level) - prev;
            if (prev - int'(fade.Level) > max_jump) max_jump = prev - int'(fade.Level);
            prev = int'(fade.Level);
        end
        check_eq("rev_peak",     32'(lvl_max),      100);
        check_eq("rev_max_jump", 32'(max_jump),     1);
        check_eq("rev_end_lvl",  32'(fade.Level),   0);
        check_eq("rev_end_ramp", 32'(fade.Ramping), 0);

        // Enable dropped for 50 cycles mid-ramp.
        len = $urandom_range(30, 300);
        for (int i = 0; i < len; i++) step(1, 1);
        lvl_frz = int'(fade.Level);
        led_hi  = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 0);
            led_hi += int'(fade.LED_OUT);
        end
        check_eq("en_led_blank", 32'(led_hi),     0);
        check_eq("en_level_frz", 32'(fade.Level), lvl_frz);
        for (int i = 0; i < 40; i++) step(1, 1);

        // Back to idle, then a single-cycle blink glitch.
        for (int i = 0; i < 1200 && !(m_lvl == 0 && m_ramp == 0); i++) step(0, 1);
        for (int i = 0; i < 4; i++) step(0, 1);
        step(1, 1);
        ramp_hi = 0; lvl_max = 0; led_hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            ramp_hi += int'(fade.Ramping);
            led_hi  += int'(fade.LED_OUT);
            if (fade.Level > lvl_max) lvl_max = int'(fade.Level);
        end
        check_eq("glitch_ramp_cycles", 32'(ramp_hi), 1);
        check_eq("glitch_level",       32'(lvl_max), 0);
        check_eq("glitch_led",         32'(led_hi),  0);

        // Random blink segments with sporadic Enable drops.
        for (int s = 0; s < 12; s++) begin
            b   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 500));
            for (int i = 0; i < len; i++) step(b, ($urandom_range(0, 9) != 0) ? 1 : 0);
        end

        // Asynchronous reset mid-ramp at Level=100.
        for (int i = 0; i < 1200 && m_lvl != 0; i++) step(0, 1);
        for (int i = 0; i < 1200 && m_lvl != 100; i++) step(1, 1);
        check_eq("mid_rst_pre_level", 32'(fade.Level), 100);
        apply_reset();
        led_hi = 0; lvl_max = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            led_hi += int'(fade.LED_OUT);
            if (fade.Level > lvl_max) lvl_max = int'(fade.Level);
        end
        check_eq("post_rst_led",  32'(led_hi),  0);
        check_eq("post_rst_lvl",  32'(lvl_max), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
